reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
Sequencing controller for the millisecond timing datapath (clock divider tick -> ms count -> BCD conversion -> seven-segment display), turning it into a reaction-time tester. It holds off for a pseudo-random delay, lights a GO indicator, and then counts milliseconds until the player reacts. It also flags false starts and timeouts, and keeps the best valid time. Its ms_count output feeds the BCD converter; best_ms can be muxed onto the display at top level.

Parameters:
MIN_DELAY_MS, 1000, fixed part of the wait before GO; must be >= 1.
RAND_BITS, 11, width of the random part of the wait (0 .. 2^RAND_BITS-1 ms added).
TIMEOUT_MS, 9999, ms count at which a run ends as a timeout.
MAX_MS, 999999, saturation limit of the 20-bit count (six display digits).
LFSR_SEED, 16'hACE1, LFSR value after reset; must be nonzero.

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
tick_ms  input  1  one-cycle enable pulse per millisecond from the clock divider
start  input  1  start button, active-high level, already debounced
react  input  1  reaction button, active-high level, already debounced
ms_count  output  20  current or frozen reaction time in ms, binary
best_ms  output  20  best (smallest) valid reaction time
best_valid  output  1  best_ms holds a real result
led_go  output  1  high while in GO
false_start  output  1  high while in FALSE_START
timeout  output  1  last run ended by timeout; cleared on the next start
busy  output  1  high in ARMED or GO
state  output  3  encoded state for debug: IDLE=0, ARMED=1, GO=2, DONE=3, FALSE_START=4

Behaviour:
- Reset (sync, active-high): state=IDLE; ms_count=0; best_ms=20'hFFFFF; best_valid=0; led_go=0; false_start=0; timeout=0; delay counter=0; LFSR=LFSR_SEED.
- All outputs are registered.
- Edge detect: start and react are each registered once. start_e = start & ~start_q. react_e is defined the same way. Only these edges act; held levels do nothing.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It advances every clk cycle, independent of tick_ms.
- IDLE:
  - start_e -> ARMED.
  - Load delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], using the LFSR value in the same cycle.
  - Clear ms_count and timeout.
- ARMED:
  - Each tick_ms decrements delay.
  - A tick with delay==1 -> GO on the next edge; led_go rises with the state. GO is therefore entered exactly D ticks after arming.
  - react_e -> FALSE_START. This wins over a simultaneous final tick.
- GO:
  - Each tick_ms does ms_count+1.
  - react_e -> DONE, with ms_count frozen. If react_e and tick_ms coincide, no increment happens.
  - On entering DONE via react: if !best_valid or ms_count < best_ms, then best_ms <= ms_count and best_valid <= 1. Equal values do not rewrite best_ms.
  - A tick that makes ms_count == TIMEOUT_MS -> DONE with timeout=1; best is not updated.
  - ms_count saturates at MAX_MS. This only matters when TIMEOUT_MS > MAX_MS.
- DONE: hold all outputs. start_e -> ARMED (reload delay, clear ms_count and timeout).
- FALSE_START: false_start=1, ms_count=0. start_e -> ARMED and clears false_start.
- In ARMED and GO, start_e is ignored. In IDLE, DONE and FALSE_START, react_e is ignored.
- Reset asserted mid-run (any state) returns to the reset values on the next edge, including clearing best.
- tick_ms is only ever a single cycle wide. No behaviour is required for a multi-cycle tick; the bench does not drive one.

Decomposition:
- Shared package: state encoding constants (IDLE..FALSE_START), the 20-bit count width, and the MAX_MS default. The top-level display mux also uses these.
- One sub-module, lfsr16 (clk, reset, seed parameter, 16-bit q), so it is reusable and can be checked in isolation.
- Edge detect and the FSM stay in reaction_timer_ctrl.

Test Plan:
1. Reset, then idle 100 cycles -> ms_count=0, best_ms=20'hFFFFF, best_valid=0, state=0, led_go=0.
2. MIN_DELAY_MS=4, RAND_BITS=2, lfsr[1:0] captured at start_e = 2. Pulse start, drive ticks every 10 cycles -> led_go rises after exactly the 6th tick. React after 37 ticks -> ms_count=37, best_ms=37, best_valid=1, state=3.
3. Second run with react after 50 ticks -> ms_count=50, best_ms stays 37. Third run with react after 20 ticks -> best_ms=20.
4. React during ARMED; also react on the same cycle as the final delay tick -> state=4, false_start=1, led_go never asserts, best unchanged. A following start_e -> ARMED with false_start=0.
5. TIMEOUT_MS=15, no react -> DONE after tick 15 with ms_count=15, timeout=1, best unchanged. react_e and tick_ms on the same cycle in GO at count 9 -> ms_count=9.
6. Hold start high across a whole run, and assert reset during GO at count 12 -> no re-arm from the held level. After reset, all outputs return to their reset values and best_valid=0.

Source files
------------

// File: rtl/reaction_timer_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reaction_timer_ctrl_pkg
// Brief    : Shared state encoding and count width for the reaction timer.
// Revision : 1.0 - initial release
// ============================================================================
package reaction_timer_ctrl_pkg;

    localparam int c_cnt_w          = 20;
    localparam int c_max_ms_default = 999999;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ARMED       = 3'd1,
        ST_GO          = 3'd2,
        ST_DONE        = 3'd3,
        ST_FALSE_START = 3'd4
    } state_t;

    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v,
                                                  input logic [c_cnt_w-1:0] lim);
        return (v >= lim) ? v : v + c_cnt_w'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_timer_ctrl_lfsr16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Brief    : 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, advancing every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5
    assign w_fb = r_q[0] ^ r_q[2] ^ r_q[3] ^ r_q[5];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= SEED;
        end else begin
            r_q <= {w_fb, r_q[15:1]};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/reaction_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reaction_timer_ctrl
// Brief    : Reaction-time tester sequencer: random hold-off, GO, ms count, best.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_timer_ctrl
    import reaction_timer_ctrl_pkg::*;
#(
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 11,
    parameter int unsigned TIMEOUT_MS   = 9999,
    parameter int unsigned MAX_MS       = c_max_ms_default,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_ms,
    input  logic               start,
    input  logic               react,
    output logic [c_cnt_w-1:0] ms_count,
    output logic [c_cnt_w-1:0] best_ms,
    output logic               best_valid,
    output logic               led_go,
    output logic               false_start,
    output logic               timeout,
    output logic               busy,
    output logic [2:0]         state
);

    localparam int c_dly_w = $clog2(MIN_DELAY_MS + (2 ** RAND_BITS)) + 1;

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_ms, w_ms_nxt, w_ms_inc;
    logic [c_cnt_w-1:0]   r_best, w_best_nxt;
    logic                 r_bv, w_bv_nxt;
    logic                 r_to, w_to_nxt;
    logic [c_dly_w-1:0]   r_dly, w_dly_nxt, w_dly_load;
    logic                 r_led_go, r_false_start, r_busy;
    logic                 r_start_q, r_react_q;
    logic                 w_start_e, w_react_e;
    logic [15:0]          w_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (w_lfsr)
    );

    generate
        if (RAND_BITS < 16) begin : g_lfsr_spare
            logic w_unused_lfsr;
            assign w_unused_lfsr = ^w_lfsr[15:RAND_BITS];
        end
    endgenerate

    // Edge history is left out of reset so a level held through reset cannot re-arm
    always_ff @(posedge clk) begin
        r_start_q <= start;
        r_react_q <= react;
    end

    assign w_start_e  = start & ~r_start_q;
    assign w_react_e  = react & ~r_react_q;
    assign w_dly_load = c_dly_w'(MIN_DELAY_MS) + c_dly_w'(w_lfsr[RAND_BITS-1:0]);
    assign w_ms_inc   = sat_inc(r_ms, c_cnt_w'(MAX_MS));

    always_comb begin
        w_state_nxt = r_state;
        w_ms_nxt    = r_ms;
        w_best_nxt  = r_best;
        w_bv_nxt    = r_bv;
        w_to_nxt    = r_to;
        w_dly_nxt   = r_dly;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FALSE_START: begin
                if (w_start_e) begin
                    w_state_nxt = ST_ARMED;
                    w_dly_nxt   = w_dly_load;
                    w_ms_nxt    = '0;
                    w_to_nxt    = 1'b0;
                end
            end
            ST_ARMED: begin
                if (w_react_e) begin
                    w_state_nxt = ST_FALSE_START;
                    w_ms_nxt    = '0;
                end else if (tick_ms) begin
                    w_dly_nxt = r_dly - c_dly_w'(1);
                    if (r_dly == c_dly_w'(1)) begin
                        w_state_nxt = ST_GO;
                    end
                end
            end
            ST_GO: begin
                // A react on a tick cycle freezes the count before the increment
                if (w_react_e) begin
                    w_state_nxt = ST_DONE;
                    if (!r_bv || (r_ms < r_best)) begin
                        w_best_nxt = r_ms;
                        w_bv_nxt   = 1'b1;
                    end
                end else if (tick_ms) begin
                    w_ms_nxt = w_ms_inc;
                    if (w_ms_inc == c_cnt_w'(TIMEOUT_MS)) begin
                        w_state_nxt = ST_DONE;
                        w_to_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ms          <= '0;
            r_best        <= '1;
            r_bv          <= 1'b0;
            r_to          <= 1'b0;
            r_dly         <= '0;
            r_led_go      <= 1'b0;
            r_false_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ms          <= w_ms_nxt;
            r_best        <= w_best_nxt;
            r_bv          <= w_bv_nxt;
            r_to          <= w_to_nxt;
            r_dly         <= w_dly_nxt;
            r_led_go      <= (w_state_nxt == ST_GO);
            r_false_start <= (w_state_nxt == ST_FALSE_START);
            r_busy        <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_GO);
        end
    end

    assign ms_count    = r_ms;
    assign best_ms     = r_best;
    assign best_valid  = r_bv;
    assign led_go      = r_led_go;
    assign false_start = r_false_start;
    assign timeout     = r_to;
    assign busy        = r_busy;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_reaction_timer_ctrl
// Brief    : Scoreboard bench for reaction_timer_ctrl (short delays, two timeouts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reaction_timer_ctrl;

    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_ARMED = 3'd1;
    localparam logic [2:0]  S_GO    = 3'd2;
    localparam logic [2:0]  S_DONE  = 3'd3;
    localparam logic [2:0]  S_FS    = 3'd4;
    localparam logic [19:0] NO_BEST = 20'hFFFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_ms = 1'b0;
    logic start = 1'b0;
    logic react = 1'b0;

    logic [19:0] a_ms, a_best, b_ms, b_best;
    logic        a_bv, a_go, a_fs, a_to, a_busy;
    logic        b_bv, b_go, b_fs, b_to, b_busy;
    logic [2:0]  a_state, b_state;

    always #10 clk = ~clk;

    reaction_timer_ctrl #(
        .MIN_DELAY_MS (4), .RAND_BITS (2), .TIMEOUT_MS (9999),
        .MAX_MS (999999), .LFSR_SEED (16'hACE1)
    ) u_dut (
        .clk (clk), .reset (reset), .tick_ms (tick_ms), .start (start), .react (react),
        .ms_count (a_ms), .best_ms (a_best), .best_valid (a_bv), .led_go (a_go),
        .false_start (a_fs), .timeout (a_to), .busy (a_busy), .state (a_state)
    );

    reaction_timer_ctrl #(
        .MIN_DELAY_MS (4), .RAND_BITS (2), .TIMEOUT_MS (15),
        .MAX_MS (999999), .LFSR_SEED (16'hACE1)
    ) u_dut_to (
        .clk (clk), .reset (reset), .tick_ms (tick_ms), .start (start), .react (react),
        .ms_count (b_ms), .best_ms (b_best), .best_valid (b_bv), .led_go (b_go),
        .false_start (b_fs), .timeout (b_to), .busy (b_busy), .state (b_state)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11+1, reseeded by reset
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    logic go_seen = 1'b0;
    logic go_clr  = 1'b0;
    always @(posedge clk) go_seen <= go_clr ? 1'b0 : (go_seen | a_go);

    typedef struct packed {
        logic [19:0] ms;
        logic [19:0] best;
        logic        bv;
        logic [2:0]  st;
        logic        go;
        logic        fs;
        logic        to;
        logic        busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string t, input logic [19:0] ms, input logic [19:0] best,
                           input logic bv, input logic [2:0] st, input logic go,
                           input logic fs, input logic to, input logic bz);
        exp_t e;
        e = '{ms: ms, best: best, bv: bv, st: st, go: go, fs: fs, to: to, busy: bz};
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic sb_compare(input bit sel_b);
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".ms_count"},    sel_b ? b_ms    : a_ms,    e.ms);
        chk({t, ".best_ms"},     sel_b ? b_best  : a_best,  e.best);
        chk({t, ".best_valid"},  sel_b ? b_bv    : a_bv,    e.bv);
        chk({t, ".state"},       sel_b ? b_state : a_state, e.st);
        chk({t, ".led_go"},      sel_b ? b_go    : a_go,    e.go);
        chk({t, ".false_start"}, sel_b ? b_fs    : a_fs,    e.fs);
        chk({t, ".timeout"},     sel_b ? b_to    : a_to,    e.to);
        chk({t, ".busy"},        sel_b ? b_busy  : a_busy,  e.busy);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1;
            @(negedge clk);
            tick_ms = 1'b0;
            repeat (9) @(negedge clk);
        end
    endtask

    // Delay the DUT will load is the LFSR value seen on the start edge
    task automatic pulse_start(output int d);
        d = 4 + int'(m_lfsr[1:0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_react(input bit with_tick);
        react   = 1'b1;
        tick_ms = with_tick;
        @(negedge clk);
        react   = 1'b0;
        tick_ms = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int k;

        // Reset and idle
        do_reset(5);
        step(100);
        sb_push("t1_reset", 20'd0, NO_BEST, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_compare(0);

        // First run, random part forced to 2 -> delay of 6 ticks
        k = 0;
        while (m_lfsr[1:0] != 2'd2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t2_lfsr_sel", {30'd0, m_lfsr[1:0]}, 32'd2);
        sb_push("t2_armed", 20'd0, NO_BEST, 1'b0, S_ARMED, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse_start(d);
        sb_compare(0);
        sb_push("t2_tick5", 20'd0, NO_BEST, 1'b0, S_ARMED, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(d - 1);
        sb_compare(0);
        sb_push("t2_tick6_go", 20'd0, NO_BEST, 1'b0, S_GO, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(1);
        sb_compare(0);
        sb_push("t2_count37", 20'd37, NO_BEST, 1'b0, S_GO, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(37);
        sb_compare(0);
        sb_push("t2_done37", 20'd37, 20'd37, 1'b1, S_DONE, 1'b0, 1'b0, 1'b0, 1'b0);
        do_react(0);
        sb_compare(0);

        // Slower run keeps best, faster run replaces it
        sb_push("t3_rearm", 20'd0, 20'd37, 1'b1, S_ARMED, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse_start(d);
        sb_compare(0);
        sb_push("t3_run50", 20'd50, 20'd37, 1'b1, S_DONE, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(d + 50);
        do_react(0);
        sb_compare(0);
        sb_push("t3_run20", 20'd20, 20'd20, 1'b1, S_DONE, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_start(d);
        ticks(d + 20);
        do_react(0);
        sb_compare(0);

        // False starts: mid-delay and on the final delay tick
        go_clr = 1'b1;
        @(negedge clk);
        go_clr = 1'b0;
        sb_push("t4_fs_mid", 20'd0, 20'd20, 1'b1, S_FS, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_start(d);
        ticks(2);
        do_react(0);
        sb_compare(0);
        sb_push("t4_rearm", 20'd0, 20'd20, 1'b1, S_ARMED, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse_start(d);
        sb_compare(0);
        sb_push("t4_fs_final", 20'd0, 20'd20, 1'b1, S_FS, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(d - 1);
        do_react(1);
        sb_compare(0);
        chk("t4_go_never", {31'd0, go_seen}, 32'd0);

        // Timeout instance: TIMEOUT_MS = 15
        do_reset(3);
        pulse_start(d);
        sb_push("t5_count14", 20'd14, NO_BEST, 1'b0, S_GO, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(d + 14);
        sb_compare(1);
        sb_push("t5_timeout", 20'd15, NO_BEST, 1'b0, S_DONE, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        sb_compare(1);
        sb_push("t5_hold", 20'd15, NO_BEST, 1'b0, S_DONE, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        sb_compare(1);
        sb_push("t5_rearm", 20'd0, NO_BEST, 1'b0, S_ARMED, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse_start(d);
        sb_compare(1);
        sb_push("t5_react_tick9", 20'd9, 20'd9, 1'b1, S_DONE, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(d + 9);
        do_react(1);
        sb_compare(1);

        // Held start and reset mid-GO
        do_reset(3);
        sb_push("t6_best25", 20'd25, 20'd25, 1'b1, S_DONE, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_start(d);
        ticks(d + 25);
        do_react(0);
        sb_compare(0);
        sb_push("t6_held_arm", 20'd0, 20'd25, 1'b1, S_ARMED, 1'b0, 1'b0, 1'b0, 1'b1);
        d = 4 + int'(m_lfsr[1:0]);
        start = 1'b1;
        @(negedge clk);
        sb_compare(0);
        sb_push("t6_go12", 20'd12, 20'd25, 1'b1, S_GO, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(d + 12);
        sb_compare(0);
        sb_push("t6_reset", 20'd0, NO_BEST, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sb_compare(0);
        sb_push("t6_no_rearm", 20'd0, NO_BEST, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        step(30);
        sb_compare(0);
        start = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
